rca_serial_sub: RTL and testbench
=================================

Name: rca_serial_sub

Overview:
Bit-serial ripple subtractor. It computes DIFF = A - B - BIN over WIDTH cycles, one bit per cycle, with a borrow chain held in a flop. It is the inverse-direction companion to the combinational ripple-carry adder. It sits on a valid/ready stream: operands arrive on an input handshake and results leave on an output handshake, so it fits pipelined datapaths where a full-width subtractor is too large.

Parameters:
WIDTH, 4, operand/result width in bits (legal range WIDTH >= 2)

Ports:
clk        input   1      rising-edge clock
rst_n      input   1      asynchronous active-low reset
in_valid   input   1      operands a/b/bin valid
in_ready   output  1      block can accept operands
a          input   WIDTH  minuend (unsigned or two's complement)
b          input   WIDTH  subtrahend
bin        input   1      borrow in
out_valid  output  1      result valid
out_ready  input   1      downstream accepts result
diff       output  WIDTH  a - b - bin, modulo 2^WIDTH
bout       output  1      final borrow; 1 iff unsigned a < b + bin
ovf        output  1      signed overflow

Behaviour:
- One clock. Reset is asynchronous and active-low: rst_n low forces the FSM to IDLE immediately, with out_valid=0, diff=0, bout=0, ovf=0, bit counter=0 and borrow flop=0. Release is sampled on the next rising clk edge.
- FSM states:
  - IDLE: in_ready=1. On an edge with in_valid&&in_ready, capture a, b and bin into internal shift registers, set borrow flop=bin and counter=0, then go to RUN.
  - RUN: in_ready=0. Each edge processes bit i = counter (LSB first) through a full-subtractor cell:
    - d_i = a_i ^ b_i ^ br
    - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)
    - d_i shifts into the result register from the MSB side; counter increments.
    - The edge that processes bit WIDTH-1 moves the FSM to DONE and loads the outputs.
  - DONE: out_valid=1, in_ready=0. diff, bout and ovf are registered and held stable until an edge with out_valid&&out_ready, then the FSM goes to IDLE.
- Latency: if operands are accepted at edge E, out_valid rises after edge E+WIDTH. Throughput is one operation per WIDTH+2 cycles with out_ready held high.
- Output flags:
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands. bin is not included in the sign test, but its effect shows through diff.
  - bout = borrow flop after the last bit.
- in_ready is combinational from state (1 only in IDLE); it reads 1 while in reset.
- a, b and bin are sampled only on the accept edge; later changes are ignored.
- in_valid during RUN or DONE is ignored; no queuing.
- out_ready held low in DONE stalls indefinitely with outputs unchanged.
- out_ready high before DONE has no effect.
- Reset mid-RUN or mid-DONE aborts the operation and discards the result; no partial output.
- Counter width is $clog2(WIDTH). The counter compares against WIDTH-1 and never wraps.

Decomposition:
- Shared package rca_pkg holds:
  - the FSM state enum {IDLE, RUN, DONE} as a 2-bit encoding;
  - constant DEFAULT_WIDTH=4.
- Sub-module fs is the 1-bit full subtractor (a, b, bin -> d, bout), the subtraction counterpart of the fa cell. It is instantiated once and reused serially each cycle.

Test Plan:
- WIDTH=4, a=5, b=3, bin=0 -> diff=2, bout=0, ovf=0; out_valid asserts exactly 4 edges after the accept edge; in_ready=0 throughout RUN.
- a=3, b=5, bin=0 -> diff=4'hE, bout=1, ovf=0. Also a=0, b=0, bin=1 -> diff=4'hF, bout=1, ovf=0.
- a=4'h8, b=1, bin=0 -> diff=7, bout=0, ovf=1 (-8-1 overflows). Also a=7, b=4'hF, bin=0 -> diff=8, bout=1, ovf=1.
- a=1, b=3, bin=1 -> diff=4'hD, bout=1, ovf=0. Operands are changed to a=F, b=F the cycle after accept; the result must be unaffected.
- Backpressure: out_ready=0 for 3 cycles in DONE -> out_valid stays 1, diff/bout/ovf stable, in_ready stays 0, and an asserted in_valid is not accepted. When out_ready rises, the handshake completes and in_ready=1 on the following cycle.
- rst_n pulsed low during the 2nd RUN cycle -> out_valid=0 and in_ready=1 immediately (asynchronous), with no result emitted. A following op a=7, b=7, bin=0 -> diff=0, bout=0, ovf=0.

Source files
------------

// File: rtl/rca_pkg.sv
// Shared definitions for the bit-serial ripple subtractor.
package rca_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rca_serial_sub_fs.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/rca_serial_sub.sv
// Bit-serial subtractor on a valid/ready stream: diff = a - b - bin over WIDTH cycles.
module rca_serial_sub
  import rca_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               br_q, br_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;

  logic               cell_d;
  logic               cell_bout;
  logic [WIDTH-1:0]   res_next;

  // Single cell reused each cycle; operands stay intact and are indexed by the counter.
  fs u_fs (
    .a    (a_q[cnt_q]),
    .b    (b_q[cnt_q]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign res_next = {cell_d, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d = res_next;
        br_d  = cell_bout;
        if (cnt_q == CNT_LAST) begin
          diff_d  = res_next;
          bout_d  = cell_bout;
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (cell_d != a_q[WIDTH-1]);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_rca_serial_sub.sv
// Randomized self-checking bench for rca_serial_sub against an arithmetic reference model.
module tb_rca_serial_sub;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  rca_serial_sub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer subtraction over the stated rules.
  task automatic model(input int unsigned ai, input int unsigned bi, input int unsigned bini,
                       output logic [W-1:0] d, output logic bo, output logic ov);
    int signed full;
    int signed sa, sb;
    full = int'(ai) - int'(bi) - int'(bini);
    d    = W'(full & ((1 << W) - 1));
    bo   = (ai < bi + bini);
    sa   = (ai >= (1 << (W - 1))) ? int'(ai) - (1 << W) : int'(ai);
    sb   = (bi >= (1 << (W - 1))) ? int'(bi) - (1 << W) : int'(bi);
    ov   = ((sa < 0) != (sb < 0)) && ((d[W-1] == 1'b1) != (sa < 0));
  endtask

  // Issue one operation from IDLE; optional operand scrambling, noise and backpressure.
  task automatic do_op(input int unsigned ai, input int unsigned bi, input int unsigned bini,
                       input int unsigned stall, input bit noisy, input bit scramble);
    logic [W-1:0] ed;
    logic         eb, eo;
    logic [W-1:0] held_d;
    logic         held_b, held_o;
    model(ai, bi, bini, ed, eb, eo);
    @(negedge clk);
    check("ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a        = W'(ai);
    b        = W'(bi);
    bin      = 1'(bini);
    @(posedge clk);
    for (int unsigned k = 0; k < W; k++) begin
      @(negedge clk);
      check("run_valid", 32'(out_valid), 32'd0);
      check("run_ready", 32'(in_ready), 32'd0);
      in_valid  = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ready = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (scramble) begin
        a = '1;
        b = '1;
        bin = 1'b1;
      end else if (noisy) begin
        a   = W'($urandom);
        b   = W'($urandom);
        bin = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
    end
    @(negedge clk);
    check("done_valid", 32'(out_valid), 32'd1);
    check("done_ready", 32'(in_ready), 32'd0);
    check("diff", 32'(diff), 32'(ed));
    check("bout", 32'(bout), 32'(eb));
    check("ovf", 32'(ovf), 32'(eo));
    held_d = diff;
    held_b = bout;
    held_o = ovf;
    out_ready = 1'b0;
    for (int unsigned s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_ready", 32'(in_ready), 32'd0);
      check("stall_diff", 32'(diff), 32'(held_d));
      check("stall_bout", 32'(bout), 32'(held_b));
      check("stall_ovf", 32'(ovf), 32'(held_o));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    do_op(5, 3, 0, 0, 1'b0, 1'b0);
    do_op(3, 5, 0, 0, 1'b0, 1'b0);
    do_op(0, 0, 1, 0, 1'b0, 1'b0);
    do_op(8, 1, 0, 0, 1'b0, 1'b0);
    do_op(7, 15, 0, 0, 1'b0, 1'b0);
    do_op(1, 3, 1, 0, 1'b0, 1'b1);
    do_op(9, 2, 1, 3, 1'b0, 1'b0);

    // Asynchronous abort during the second RUN cycle.
    @(negedge clk);
    in_valid = 1'b1;
    a = W'(4'h9);
    b = W'(4'h6);
    bin = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    #1 rst_n = 1'b1;
    for (int unsigned k = 0; k < W + 2; k++) begin
      @(negedge clk);
      check("abort_quiet", 32'(out_valid), 32'd0);
    end
    do_op(7, 7, 0, 0, 1'b0, 1'b0);

    for (int unsigned i = 0; i < 40; i++)
      do_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1),
            $urandom_range(0, 3), 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
